// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for a multicycle RV32 datapath that has one shared
// instruction/data memory, an IR, an OldPC register, an ALUOut register and a
// single ALU. Each instruction walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
//
// Ports:
//   iCLK, iRST_N       clock (rising edge), synchronous active-low reset
//   iInst[31:0]        IR contents, valid from DECODE onward
//   iMemReady          memory finished the current read/write this cycle
//   oPCWrite           unconditional PC load
//   oPCWriteCond       PC load gated by ALU zero
//   oIorD              memory address select (0=PC, 1=ALUOut)
//   oMemRead/oMemWrite memory requests
//   oIRWrite           IR and OldPC load
//   oMemtoReg[1:0]     write-back select (00=ALUOut, 01=MDR, 10=PC)
//   oRegWrite          register file write enable
//   oALUSrcA[1:0]      ALU A select (00=PC, 01=rs1, 10=OldPC)
//   oALUSrcB[1:0]      ALU B select (00=rs2, 01=4, 10=imm)
//   oALUControl[2:0]   ALU op (AND/OR/ADD/XOR/SUB/SLT)
//   oOrigPC[1:0]       PC source (00=ALU result, 01=ALUOut)
//   oState[3:0]        current state, for debug
//   oInstRetired       pulse in the last cycle of each instruction
//   oIllegal           high while parked in ILLEGAL
module multicycle_control_fsm #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [31:0] iInst,
  input  logic        iMemReady,
  output logic        oPCWrite,
  output logic        oPCWriteCond,
  output logic        oIorD,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oIRWrite,
  output logic [1:0]  oMemtoReg,
  output logic        oRegWrite,
  output logic [1:0]  oALUSrcA,
  output logic [1:0]  oALUSrcB,
  output logic [2:0]  oALUControl,
  output logic [1:0]  oOrigPC,
  output logic [3:0]  oState,
  output logic        oInstRetired,
  output logic        oIllegal
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE= 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EX_R     = 4'd2,
    S_EX_I     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JAL      = 4'd9,
    S_ALU_WB   = 4'd10,
    S_ILLEGAL  = 4'd15
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt, cnt_inc;
  logic              in_wait;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_inst;

  assign opcode      = iInst[6:0];
  assign funct3      = iInst[14:12];
  assign funct7      = iInst[31:25];
  assign unused_inst = ^{iInst[24:15], iInst[11:7]};
  assign oState      = state;

  // State and memory-wait counter
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state and Moore/handshake-qualified outputs
  always_comb begin
    state_nxt    = state;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oIRWrite     = 1'b0;
    oMemtoReg    = 2'b00;
    oRegWrite    = 1'b0;
    oALUSrcA     = 2'b00;
    oALUSrcB     = 2'b00;
    oALUControl  = ALU_AND;
    oOrigPC      = 2'b00;
    oInstRetired = 1'b0;
    oIllegal     = 1'b0;

    case (state)
      S_FETCH: begin
        oMemRead    = 1'b1;
        oALUSrcB    = 2'b01;
        oALUControl = ALU_ADD;
        if (iMemReady) begin
          oIRWrite  = 1'b1;
          oPCWrite  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // OldPC + imm precomputes the branch/jal target into ALUOut
        oALUSrcA    = 2'b10;
        oALUSrcB    = 2'b10;
        oALUControl = ALU_ADD;
        case (opcode)
          OP_R:              state_nxt = S_EX_R;
          OP_I:              state_nxt = S_EX_I;
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
          OP_BR:             state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          default:           state_nxt = S_ILLEGAL;
        endcase
      end
      S_EX_R: begin
        oALUSrcA  = 2'b01;
        state_nxt = S_ALU_WB;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000)      oALUControl = ALU_ADD;
            else if (funct7 == 7'b0100000) oALUControl = ALU_SUB;
            else                           state_nxt   = S_ILLEGAL;
          end
          3'b111:  oALUControl = ALU_AND;
          3'b110:  oALUControl = ALU_OR;
          3'b010:  oALUControl = ALU_SLT;
          default: state_nxt   = S_ILLEGAL;
        endcase
      end
      S_EX_I: begin
        oALUSrcA  = 2'b01;
        oALUSrcB  = 2'b10;
        state_nxt = S_ALU_WB;
        case (funct3)
          3'b000:  oALUControl = ALU_ADD;
          3'b111:  oALUControl = ALU_AND;
          3'b110:  oALUControl = ALU_OR;
          3'b100:  oALUControl = ALU_XOR;
          default: state_nxt   = S_ILLEGAL;
        endcase
      end
      S_ALU_WB: begin
        oRegWrite    = 1'b1;
        oInstRetired = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEM_ADDR: begin
        oALUSrcA    = 2'b01;
        oALUSrcB    = 2'b10;
        oALUControl = ALU_ADD;
        state_nxt   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        oMemRead = 1'b1;
        oIorD    = 1'b1;
        if (iMemReady) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        oRegWrite    = 1'b1;
        oMemtoReg    = 2'b01;
        oInstRetired = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEM_WR: begin
        oMemWrite = 1'b1;
        oIorD     = 1'b1;
        if (iMemReady) begin
          oInstRetired = 1'b1;
          state_nxt    = S_FETCH;
        end
      end
      S_BRANCH: begin
        oALUSrcA     = 2'b01;
        oALUControl  = ALU_SUB;
        oPCWriteCond = 1'b1;
        oOrigPC      = 2'b01;
        oInstRetired = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_JAL: begin
        oRegWrite    = 1'b1;
        oMemtoReg    = 2'b10;
        oPCWrite     = 1'b1;
        oOrigPC      = 2'b01;
        oInstRetired = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_ILLEGAL: oIllegal = 1'b1;
      default:   state_nxt = S_ILLEGAL;
    endcase

    // Memory wait timeout; a ready in the limit cycle advances normally
    in_wait = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR))
              && !iMemReady;
    cnt_inc = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + CNT_W'(1);
    if (in_wait && (MEM_TIMEOUT != 8'd0) && (cnt_inc == MEM_TIMEOUT))
      state_nxt = S_ILLEGAL;

    if (state_nxt != state) wait_cnt_nxt = '0;
    else if (in_wait)       wait_cnt_nxt = cnt_inc;
    else                    wait_cnt_nxt = wait_cnt;

    // Reset held low: no strobe may reach the datapath
    if (!iRST_N) begin
      oPCWrite     = 1'b0;
      oPCWriteCond = 1'b0;
      oMemRead     = 1'b0;
      oMemWrite    = 1'b0;
      oIRWrite     = 1'b0;
      oRegWrite    = 1'b0;
      oInstRetired = 1'b0;
      oIllegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm: per-cycle vector table, hand-written
// multi-cycle sequences and randomized instructions checked against an
// instruction-level latency/strobe model.
module tb_multicycle_control_fsm;

  localparam logic [7:0] TO = 8'd4;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [31:0] iInst;
  logic        iMemReady;
  logic        oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite;
  logic [1:0]  oMemtoReg;
  logic        oRegWrite;
  logic [1:0]  oALUSrcA, oALUSrcB;
  logic [2:0]  oALUControl;
  logic [1:0]  oOrigPC;
  logic [3:0]  oState;
  logic        oInstRetired, oIllegal;

  multicycle_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iInst(iInst), .iMemReady(iMemReady),
    .oPCWrite(oPCWrite), .oPCWriteCond(oPCWriteCond), .oIorD(oIorD),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oIRWrite(oIRWrite),
    .oMemtoReg(oMemtoReg), .oRegWrite(oRegWrite), .oALUSrcA(oALUSrcA),
    .oALUSrcB(oALUSrcB), .oALUControl(oALUControl), .oOrigPC(oOrigPC),
    .oState(oState), .oInstRetired(oInstRetired), .oIllegal(oIllegal)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction constants
  localparam logic [31:0] ADDI = 32'h00A28293;
  localparam logic [31:0] SUB  = 32'h40B50533;
  localparam logic [31:0] SLT  = 32'h00B52533;
  localparam logic [31:0] LW   = 32'h0042A303;
  localparam logic [31:0] SW   = 32'h0062A223;
  localparam logic [31:0] BEQ  = 32'h00B50463;
  localparam logic [31:0] JAL  = 32'h008000EF;
  localparam logic [31:0] BAD  = 32'h0000007F;

  // Strobe bits {PCWrite,PCWriteCond,MemRead,MemWrite,IRWrite,RegWrite,InstRetired}
  localparam logic [6:0] PCW = 7'b1000000, PCWC = 7'b0100000, MRD = 7'b0010000,
                         MWR = 7'b0001000, IRW = 7'b0000100, RGW = 7'b0000010,
                         RET = 7'b0000001, NONE = 7'b0;
  // Mux fields {IorD,MemtoReg,ALUSrcA,ALUSrcB,OrigPC}
  localparam logic [8:0] M_FETCH = 9'b0_00_00_01_00, M_DEC = 9'b0_00_10_10_00,
                         M_EXR   = 9'b0_00_01_00_00, M_EXI = 9'b0_00_01_10_00,
                         M_MEM   = 9'b1_00_00_00_00, M_MWB = 9'b0_01_00_00_00,
                         M_BR    = 9'b0_00_01_00_01, M_JAL = 9'b0_10_00_00_01,
                         M_NONE  = 9'b0;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                         A_XOR = 3'b011, A_SUB = 3'b110, A_SLT = 3'b111;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic [31:0] inst;
    logic [3:0]  st;
    logic [6:0]  strb;
    logic [8:0]  mux;
    logic [2:0]  alu;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic rdy, input logic [31:0] inst,
                     input logic [3:0] st, input logic [6:0] strb, input logic [8:0] mux,
                     input logic [2:0] alu, input logic ill);
    vec_t v;
    v.rst_n = rst_n; v.rdy = rdy; v.inst = inst; v.st = st;
    v.strb = strb; v.mux = mux; v.alu = alu; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST_N = 1'b0; iMemReady = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  // Runs one instruction from FETCH; memory is not ready for fw cycles in FETCH
  // and mw cycles in the data phase. Called and returns at a negedge.
  task automatic run_instr(input logic [31:0] inst, input int fw, input int mw,
                           output int cycles, output int regw, output int memw,
                           output int memrd, output int ret, output logic ill,
                           output logic [2:0] alu, output logic [1:0] mtr,
                           output logic done);
    int fcnt = 0, mcnt = 0;
    logic rdy;
    cycles = 0; regw = 0; memw = 0; memrd = 0; ret = 0;
    ill = 1'b0; alu = 3'bx; mtr = 2'bx; done = 1'b0;
    iInst = inst;
    while (!done && cycles < 40) begin
      if (oState == 4'd0) begin
        rdy = (fcnt >= fw); if (!rdy) fcnt++;
      end else if (oState == 4'd5 || oState == 4'd7) begin
        rdy = (mcnt >= mw); if (!rdy) mcnt++;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      iMemReady = rdy;
      #1;
      cycles++;
      if (oRegWrite) regw++;
      if (oMemWrite) memw++;
      if (oMemRead)  memrd++;
      if (oState == 4'd2 || oState == 4'd3) alu = oALUControl;
      if (oInstRetired) begin ret++; mtr = oMemtoReg; done = 1'b1; end
      if (oIllegal) begin ill = 1'b1; done = 1'b1; end
      @(negedge iCLK);
    end
  endtask

  // Instruction classes derived from opcode/funct fields
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_JAL = 5, K_BAD = 6;

  function automatic int kind_of(input logic [31:0] inst);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = inst[14:12]; f7 = inst[31:25];
    case (inst[6:0])
      7'b0110011: begin
        if (f3 == 3'b000) return (f7 == 7'h00 || f7 == 7'h20) ? K_R : K_BAD;
        return (f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010) ? K_R : K_BAD;
      end
      7'b0010011: return (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b100) ? K_I : K_BAD;
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b1100011: return K_BEQ;
      7'b1101111: return K_JAL;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] inst);
    logic [2:0] f3;
    f3 = inst[14:12];
    if (inst[6:0] == 7'b0110011) begin
      case (f3)
        3'b000:  return inst[30] ? A_SUB : A_ADD;
        3'b111:  return A_AND;
        3'b110:  return A_OR;
        default: return A_SLT;
      endcase
    end
    case (f3)
      3'b000:  return A_ADD;
      3'b111:  return A_AND;
      3'b110:  return A_OR;
      default: return A_XOR;
    endcase
  endfunction

  int cyc, rw, mwc, mrc, rt;
  logic il, dn;
  logic [2:0] al;
  logic [1:0] mt;

  initial begin
    iRST_N = 1'b0; iMemReady = 1'b0; iInst = 32'h0;
    repeat (2) @(negedge iCLK);

    // ---- per-cycle vector table ----
    add(0,1,ADDI, 0, NONE,        M_FETCH, A_ADD, 0);
    add(1,1,ADDI, 0, PCW|MRD|IRW, M_FETCH, A_ADD, 0);
    add(1,1,ADDI, 1, NONE,        M_DEC,   A_ADD, 0);
    add(1,1,ADDI, 3, NONE,        M_EXI,   A_ADD, 0);
    add(1,1,ADDI,10, RGW|RET,     M_NONE,  A_AND, 0);
    add(1,1,SUB,  0, PCW|MRD|IRW, M_FETCH, A_ADD, 0);
    add(1,1,SUB,  1, NONE,        M_DEC,   A_ADD, 0);
    add(1,1,SUB,  2, NONE,        M_EXR,   A_SUB, 0);
    add(1,1,SUB, 10, RGW|RET,     M_NONE,  A_AND, 0);
    add(1,1,SLT,  0, PCW|MRD|IRW, M_FETCH, A_ADD, 0);
    add(1,1,SLT,  1, NONE,        M_DEC,   A_ADD, 0);
    add(1,1,SLT,  2, NONE,        M_EXR,   A_SLT, 0);
    add(1,1,SLT, 10, RGW|RET,     M_NONE,  A_AND, 0);
    add(1,1,SW,   0, PCW|MRD|IRW, M_FETCH, A_ADD, 0);
    add(1,1,SW,   1, NONE,        M_DEC,   A_ADD, 0);
    add(1,1,SW,   4, NONE,        M_EXI,   A_ADD, 0);
    add(1,0,SW,   7, MWR,         M_MEM,   A_AND, 0);
    add(1,1,SW,   7, MWR|RET,     M_MEM,   A_AND, 0);
    add(1,1,BEQ,  0, PCW|MRD|IRW, M_FETCH, A_ADD, 0);
    add(1,1,BEQ,  1, NONE,        M_DEC,   A_ADD, 0);
    add(1,1,BEQ,  8, PCWC|RET,    M_BR,    A_SUB, 0);
    add(1,1,JAL,  0, PCW|MRD|IRW, M_FETCH, A_ADD, 0);
    add(1,1,JAL,  1, NONE,        M_DEC,   A_ADD, 0);
    add(1,1,JAL,  9, PCW|RGW|RET, M_JAL,   A_AND, 0);
    add(1,0,BAD,  0, MRD,         M_FETCH, A_ADD, 0);
    add(1,1,BAD,  0, PCW|MRD|IRW, M_FETCH, A_ADD, 0);
    add(1,1,BAD,  1, NONE,        M_DEC,   A_ADD, 0);
    add(1,1,BAD, 15, NONE,        M_NONE,  A_AND, 1);
    add(1,1,BAD, 15, NONE,        M_NONE,  A_AND, 1);
    add(0,1,BAD, 15, NONE,        M_NONE,  A_AND, 0);
    add(1,1,SW,   0, PCW|MRD|IRW, M_FETCH, A_ADD, 0);
    add(1,1,SW,   1, NONE,        M_DEC,   A_ADD, 0);
    add(1,1,SW,   4, NONE,        M_EXI,   A_ADD, 0);
    add(0,0,SW,   7, NONE,        M_MEM,   A_AND, 0);
    add(1,0,SW,   0, MRD,         M_FETCH, A_ADD, 0);

    foreach (vecs[i]) begin
      iRST_N = vecs[i].rst_n; iMemReady = vecs[i].rdy; iInst = vecs[i].inst;
      #1;
      check($sformatf("vec%0d state", i), 32'(oState), 32'(vecs[i].st));
      check($sformatf("vec%0d strobes", i),
            32'({oPCWrite,oPCWriteCond,oMemRead,oMemWrite,oIRWrite,oRegWrite,oInstRetired}),
            32'(vecs[i].strb));
      check($sformatf("vec%0d muxes", i),
            32'({oIorD,oMemtoReg,oALUSrcA,oALUSrcB,oOrigPC}), 32'(vecs[i].mux));
      check($sformatf("vec%0d alu", i), 32'(oALUControl), 32'(vecs[i].alu));
      check($sformatf("vec%0d illegal", i), 32'(oIllegal), 32'(vecs[i].ill));
      @(negedge iCLK);
    end

    // ---- lw with three data wait cycles ----
    do_reset();
    run_instr(LW, 0, 3, cyc, rw, mwc, mrc, rt, il, al, mt, dn);
    check("lw_done", 32'(dn), 32'd1);
    check("lw_cycles", 32'(cyc), 32'd8);
    check("lw_memread_cycles", 32'(mrc), 32'd5);
    check("lw_memtoreg", 32'(mt), 32'd1);
    check("lw_regwrite", 32'(rw), 32'd1);

    // ---- sw zero-wait ----
    run_instr(SW, 0, 0, cyc, rw, mwc, mrc, rt, il, al, mt, dn);
    check("sw_cycles", 32'(cyc), 32'd4);
    check("sw_regwrite", 32'(rw), 32'd0);
    check("sw_memwrite", 32'(mwc), 32'd1);

    // ---- fetch timeout: 4 stalled FETCH cycles then ILLEGAL ----
    run_instr(ADDI, 1000, 0, cyc, rw, mwc, mrc, rt, il, al, mt, dn);
    check("timeout_illegal", 32'(il), 32'd1);
    check("timeout_cycles", 32'(cyc), 32'(int'(TO) + 1));
    check("timeout_retired", 32'(rt), 32'd0);
    do_reset();

    // ---- randomized instructions against the instruction-level model ----
    for (int n = 0; n < 80; n++) begin
      logic [31:0] inst;
      int pick, k, fw, mw, r, base;
      logic exp_ill;
      logic [2:0] f3s_r[4];
      logic [2:0] f3s_i[4];
      f3s_r = '{3'b000, 3'b111, 3'b110, 3'b010};
      f3s_i = '{3'b000, 3'b111, 3'b110, 3'b100};
      inst = $urandom;
      pick = $urandom_range(0, 7);
      case (pick)
        0, 6: inst[6:0] = 7'b0110011;
        1:    inst[6:0] = 7'b0010011;
        2:    inst[6:0] = 7'b0000011;
        3:    inst[6:0] = 7'b0100011;
        4:    inst[6:0] = 7'b1100011;
        5:    inst[6:0] = 7'b1101111;
        default: ;
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (inst[6:0] == 7'b0110011) begin
          inst[14:12] = f3s_r[$urandom_range(0, 3)];
          inst[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end else if (inst[6:0] == 7'b0010011) begin
          inst[14:12] = f3s_i[$urandom_range(0, 3)];
        end
      end
      r  = $urandom_range(0, 15); fw = (r < 12) ? r % 3 : ((r < 15) ? 3 : 4);
      r  = $urandom_range(0, 15); mw = (r < 12) ? r % 3 : ((r < 15) ? 3 : 4);
      k  = kind_of(inst);

      run_instr(inst, fw, mw, cyc, rw, mwc, mrc, rt, il, al, mt, dn);
      check($sformatf("rnd%0d done", n), 32'(dn), 32'd1);

      exp_ill = (fw >= int'(TO)) || (k == K_BAD) ||
                ((k == K_LW || k == K_SW) && mw >= int'(TO));
      check($sformatf("rnd%0d illegal %h", n, inst), 32'(il), 32'(exp_ill));
      check($sformatf("rnd%0d retired %h", n, inst), 32'(rt), exp_ill ? 32'd0 : 32'd1);
      if (exp_ill) begin
        check($sformatf("rnd%0d regwrite %h", n, inst), 32'(rw), 32'd0);
        check($sformatf("rnd%0d memwrite %h", n, inst), 32'(mwc),
              (fw < int'(TO) && k == K_SW) ? 32'(int'(TO)) : 32'd0);
        do_reset();
      end else begin
        case (k)
          K_R, K_I: base = 4;
          K_LW:     base = 5;
          K_SW:     base = 4;
          default:  base = 3;
        endcase
        if (k == K_LW || k == K_SW) base += mw;
        check($sformatf("rnd%0d cycles %h", n, inst), 32'(cyc), 32'(base + fw));
        check($sformatf("rnd%0d regwrite %h", n, inst), 32'(rw),
              (k == K_SW || k == K_BEQ) ? 32'd0 : 32'd1);
        check($sformatf("rnd%0d memwrite %h", n, inst), 32'(mwc),
              (k == K_SW) ? 32'(1 + mw) : 32'd0);
        check($sformatf("rnd%0d memread %h", n, inst), 32'(mrc),
              32'(1 + fw + ((k == K_LW) ? 1 + mw : 0)));
        if (k == K_R || k == K_I)
          check($sformatf("rnd%0d alu %h", n, inst), 32'(al), 32'(alu_of(inst)));
        if (k == K_LW)
          check($sformatf("rnd%0d memtoreg %h", n, inst), 32'(mt), 32'd1);
        if (k == K_JAL)
          check($sformatf("rnd%0d memtoreg %h", n, inst), 32'(mt), 32'd2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore control sequencer for the multicycle RV32 datapath variant: a shared instruction/data memory, an IR, an OldPC register, an ALUOut register and a single ALU.
- Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives all datapath enables and mux selects, and stalls on a memory-ready handshake.
- Supported: R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/xori), lw, sw, beq, jal.

Parameters:
- MEM_TIMEOUT, 8'd255, maximum cycles to wait for iMemReady before entering ILLEGAL; 0 disables the timeout.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST_N  in  1  synchronous active-low reset.
- iInst  in  32  IR contents; valid from DECODE onward.
- iMemReady  in  1  memory has completed the current read or write this cycle.
- oPCWrite  out  1  unconditional PC load.
- oPCWriteCond  out  1  PC load gated by ALU zero (branch).
- oIorD  out  1  memory address select: 0=PC, 1=ALUOut.
- oMemRead  out  1  memory read request.
- oMemWrite  out  1  memory write request.
- oIRWrite  out  1  IR load; OldPC load.
- oMemtoReg  out  2  register write-back select: 00=ALUOut, 01=MDR, 10=PC (return address).
- oRegWrite  out  1  register file write enable.
- oALUSrcA  out  2  ALU A select: 00=PC, 01=rs1, 10=OldPC.
- oALUSrcB  out  2  ALU B select: 00=rs2, 01=const 4, 10=imm.
- oALUControl  out  3  ALU operation: AND=000, OR=001, ADD=010, XOR=011, SUB=110, SLT=111.
- oOrigPC  out  2  PC source select: 00=ALU result, 01=ALUOut.
- oState  out  4  current state, for debug.
- oInstRetired  out  1  one-cycle pulse in the final cycle of each instruction.
- oIllegal  out  1  sticky; high while in ILLEGAL.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EX_R=2, EX_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JAL=9, ALU_WB=10, ILLEGAL=15.
- Registers: state and wait counter only. All other outputs decode combinationally from state, iInst and iMemReady.
- Any output not listed for a state is 0.
- Reset: iRST_N=0 at an edge → state=FETCH, wait counter=0.
  - While iRST_N=0, every strobe is forced to 0 (oPCWrite, oPCWriteCond, oMemRead, oMemWrite, oIRWrite, oRegWrite, oInstRetired).
  - oIllegal=0.
  - Reset mid-instruction aborts it with no write issued.
- FETCH:
  - oMemRead=1, oIorD=0, SrcA=00, SrcB=01, ADD.
  - If iMemReady=1: oIRWrite=1, oPCWrite=1, oOrigPC=00, next=DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - SrcA=10, SrcB=10, ADD (branch/jal target into ALUOut).
  - Next state by iInst[6:0]: 0110011→EX_R, 0010011→EX_I, 0000011/0100011→MEM_ADDR, 1100011→BRANCH, 1101111→JAL, other→ILLEGAL.
- EX_R: SrcA=01, SrcB=00.
  - ALU op by funct3: 000 → ADD if funct7=0000000, SUB if funct7=0100000, else ILLEGAL.
  - 111→AND, 110→OR, 010→SLT, other funct3→ILLEGAL.
  - Next=ALU_WB.
- EX_I: SrcA=01, SrcB=10.
  - ALU op by funct3: 000→ADD, 111→AND, 110→OR, 100→XOR, other→ILLEGAL.
  - Next=ALU_WB.
- ALU_WB: oRegWrite=1, oMemtoReg=00, oInstRetired=1, next=FETCH.
- MEM_ADDR: SrcA=01, SrcB=10, ADD; next=MEM_RD if opcode=load, else MEM_WR.
- MEM_RD: oMemRead=1, oIorD=1; advance to MEM_WB on iMemReady.
- MEM_WB: oRegWrite=1, oMemtoReg=01, oInstRetired=1, next=FETCH.
- MEM_WR: oMemWrite=1, oIorD=1.
  - oInstRetired=1 in the iMemReady cycle; next=FETCH on iMemReady.
  - Hold oMemWrite until iMemReady.
- BRANCH: SrcA=01, SrcB=00, SUB, oPCWriteCond=1, oOrigPC=01, oInstRetired=1, next=FETCH.
- JAL: oRegWrite=1, oMemtoReg=10, oPCWrite=1, oOrigPC=01, oInstRetired=1, next=FETCH.
- ILLEGAL: all strobes 0, oIllegal=1; held until reset.
- Memory wait timeout:
  - The wait counter increments each cycle spent in FETCH/MEM_RD/MEM_WR with iMemReady=0, and clears on state change.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT → ILLEGAL.
  - If iMemReady=1 in the same cycle the count hits the limit, the ready wins.
- Latency with zero-wait memory:
  - R/I-type: 4 cycles; lw: 5; sw: 4; beq: 3; jal: 3.
  - Each wait cycle adds 1.
- iMemReady outside FETCH/MEM_RD/MEM_WR is ignored.

Test Plan:
- Reset, then iMemReady=1, iInst=0x00A28293 (addi) → states 0,1,3,10,0; oRegWrite=1 only in state 10; oALUControl=010 in EX_I; exactly one oInstRetired pulse.
- iInst=0x40B50533 (sub) → oALUControl=110 in EX_R; iInst=0x00B52533 (slt) → 111.
- lw 0x0042A303 with iMemReady low for 3 cycles in MEM_RD → oMemRead held 3+1 cycles; total 8 cycles; oMemtoReg=01 at writeback.
- sw 0x0062A223 → oMemWrite=1, oIorD=1 in state 7; oRegWrite never asserted; 4 cycles.
- beq 0x00B50463 → oPCWriteCond=1, oOrigPC=01, ALU SUB in state 8; jal 0x008000EF → oPCWrite=1, oRegWrite=1, oMemtoReg=10 in state 9.
- Opcode 0x7F → ILLEGAL (oState=15, oIllegal=1, no strobes) until iRST_N=0.
- iMemReady stuck low in FETCH with MEM_TIMEOUT=4 → ILLEGAL after 4 cycles.
- Reset asserted during MEM_WR → oMemWrite=0 that cycle; FETCH next.
